gpio_irq_ctrl: RTL and testbench

GPIO_IRQ_CTRL -- requirements
Module: gpio_irq_ctrl

---
 rtl/gpio_irq_pkg.sv | 32 +++
 rtl/gpio_sync_edge.sv | 34 +++
 rtl/gpio_irq_ctrl.sv | 123 ++++++++++++
 tb/tb_gpio_irq_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_irq_pkg.sv
// Shared constants for the GPIO interrupt controller: register map,
// default pin count, register reset values and a byte-lane helper.
package gpio_irq_pkg;

  localparam int NGPIO_DEFAULT = 16;

  localparam logic [7:0] OFF_DATA_IN  = 8'h00;
  localparam logic [7:0] OFF_DATA_OUT = 8'h04;
  localparam logic [7:0] OFF_DIR      = 8'h08;
  localparam logic [7:0] OFF_IRQ_EN   = 8'h0C;
  localparam logic [7:0] OFF_IRQ_TYPE = 8'h10;
  localparam logic [7:0] OFF_IRQ_STAT = 8'h14;

  localparam logic [31:0] RST_DATA_OUT = 32'h0000_0000;
  localparam logic [31:0] RST_DIR      = 32'h0000_0000;
  localparam logic [31:0] RST_IRQ_EN   = 32'h0000_0000;
  localparam logic [31:0] RST_IRQ_TYPE = 32'h0000_0000;
  localparam logic [31:0] RST_IRQ_STAT = 32'h0000_0000;

  // Arm counter value at which edge events start being honoured.
  localparam logic [1:0] ARM_DONE = 2'd3;

  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    logic [31:0] mask;
    mask = '0;
    for (int b = 0; b < 4; b++) begin
      mask[b*8 +: 8] = {8{sel[b]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Two-flop pad synchronizer with a one-cycle history register, producing
// per-bit rising and falling edge events on the synchronized value.
module gpio_sync_edge #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] sync,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [W-1:0] sync1;
  logic [W-1:0] sync2;
  logic [W-1:0] prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= d;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign sync = sync2;
  assign rise = sync2 & ~prev;
  assign fall = ~sync2 & prev;

endmodule

// File: rtl/gpio_irq_ctrl.sv
// Wishbone-controlled GPIO block with per-pin direction, output data and
// sticky edge-triggered interrupt status feeding irq[0].
module gpio_irq_ctrl
  import gpio_irq_pkg::*;
#(
  parameter int          NGPIO     = NGPIO_DEFAULT,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  input  logic [NGPIO-1:0] io_in,
  output logic [NGPIO-1:0] io_out,
  output logic [NGPIO-1:0] io_oeb,
  output logic [2:0]       irq
);

  logic [NGPIO-1:0] data_out;
  logic [NGPIO-1:0] dir;
  logic [NGPIO-1:0] irq_en;
  logic [NGPIO-1:0] irq_type;
  logic [NGPIO-1:0] irq_stat;
  logic [NGPIO-1:0] data_in;
  logic [NGPIO-1:0] rise;
  logic [NGPIO-1:0] fall;
  logic [NGPIO-1:0] evt;
  logic [NGPIO-1:0] set_bits;
  logic [NGPIO-1:0] clr_bits;
  logic             ack;
  logic [31:0]      rdata;
  logic [31:0]      rd_mux;
  logic [31:0]      wmask;
  logic [1:0]       arm;
  logic             hit;
  logic             req;
  logic             wr;
  logic [7:0]       off;

  function automatic logic [NGPIO-1:0] merge(input logic [NGPIO-1:0] old,
                                             input logic [31:0] d,
                                             input logic [31:0] m);
    logic [31:0] t;
    t = (32'(old) & ~m) | (d & m);
    return t[NGPIO-1:0];
  endfunction

  assign hit   = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign off   = wbs_adr_i[7:0];
  assign req   = wbs_cyc_i & wbs_stb_i & hit & ~ack;
  assign wr    = req & wbs_we_i;
  assign wmask = lane_mask(wbs_sel_i);

  gpio_sync_edge #(.W(NGPIO)) u_sync_edge (
    .clk  (wb_clk_i),
    .rst  (wb_rst_i),
    .d    (io_in),
    .sync (data_in),
    .rise (rise),
    .fall (fall)
  );

  // Events are masked until the arm counter saturates so the zeroed
  // synchronizer pipeline cannot fake an edge right after reset.
  assign evt      = (rise & ~irq_type) | (fall & irq_type);
  assign set_bits = (arm == ARM_DONE) ? (evt & irq_en) : '0;
  assign clr_bits = (wr && off == OFF_IRQ_STAT) ?
                    (wbs_dat_i[NGPIO-1:0] & wmask[NGPIO-1:0]) : '0;

  always_comb begin
    rd_mux = '0;
    case (off)
      OFF_DATA_IN:  rd_mux = 32'(data_in);
      OFF_DATA_OUT: rd_mux = 32'(data_out);
      OFF_DIR:      rd_mux = 32'(dir);
      OFF_IRQ_EN:   rd_mux = 32'(irq_en);
      OFF_IRQ_TYPE: rd_mux = 32'(irq_type);
      OFF_IRQ_STAT: rd_mux = 32'(irq_stat);
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack      <= 1'b0;
      rdata    <= '0;
      arm      <= '0;
      data_out <= RST_DATA_OUT[NGPIO-1:0];
      dir      <= RST_DIR[NGPIO-1:0];
      irq_en   <= RST_IRQ_EN[NGPIO-1:0];
      irq_type <= RST_IRQ_TYPE[NGPIO-1:0];
      irq_stat <= RST_IRQ_STAT[NGPIO-1:0];
    end else begin
      ack   <= req;
      rdata <= req ? rd_mux : '0;
      if (arm != ARM_DONE) arm <= arm + 2'd1;
      if (wr) begin
        case (off)
          OFF_DATA_OUT: data_out <= merge(data_out, wbs_dat_i, wmask);
          OFF_DIR:      dir      <= merge(dir, wbs_dat_i, wmask);
          OFF_IRQ_EN:   irq_en   <= merge(irq_en, wbs_dat_i, wmask);
          OFF_IRQ_TYPE: irq_type <= merge(irq_type, wbs_dat_i, wmask);
          default: ;
        endcase
      end
      // A new event outranks a simultaneous write-1-to-clear.
      irq_stat <= (irq_stat & ~clr_bits) | set_bits;
    end
  end

  assign wbs_ack_o = ack;
  assign wbs_dat_o = ack ? rdata : '0;
  assign io_out    = data_out;
  assign io_oeb    = ~dir;
  assign irq       = {2'b00, |irq_stat};

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Self-checking bench for gpio_irq_ctrl: a pin-history/register model is
// compared every cycle, and directed scenarios pin literal expectations.
module tb_gpio_irq_ctrl;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk;
  logic        rst;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_i;
  logic        ack;
  logic [31:0] dat_o;
  logic [15:0] io_in;
  logic [15:0] io_out;
  logic [15:0] io_oeb;
  logic [2:0]  irq;

  int errors = 0;
  int checks = 0;

  gpio_irq_ctrl #(.NGPIO(16), .BASE_ADDR(BASE)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (dat_i),
    .wbs_ack_o (ack),
    .wbs_dat_o (dat_o),
    .io_in     (io_in),
    .io_out    (io_out),
    .io_oeb    (io_oeb),
    .irq       (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Pin history: h1/h2/h3 are the pad samples taken 1/2/3 edges ago
  // (zero for samples taken while reset was asserted).
  logic [15:0] m_out, m_dir, m_en, m_type, m_stat, h1, h2, h3;
  logic        m_ack;
  logic [31:0] m_rd;
  int          since;
  bit          started = 1'b0;

  function automatic logic [15:0] merge16(input logic [15:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] t;
    t = {16'h0000, old};
    for (int b = 0; b < 4; b++) if (s[b]) t[b*8 +: 8] = d[b*8 +: 8];
    return t[15:0];
  endfunction

  always @(posedge clk) begin : model
    logic        req;
    logic [15:0] set_m, clr_m;
    logic [31:0] rv;
    started = 1'b1;
    if (rst) begin
      m_out = 0; m_dir = 0; m_en = 0; m_type = 0; m_stat = 0;
      m_ack = 0; m_rd = 0; h1 = 0; h2 = 0; h3 = 0; since = 0;
    end else begin
      req = cyc && stb && (adr[31:8] == BASE[31:8]) && !m_ack;
      set_m = 16'h0;
      if (since >= 3)
        for (int i = 0; i < 16; i++)
          if (m_en[i] && (m_type[i] ? (h3[i] && !h2[i]) : (!h3[i] && h2[i]))) set_m[i] = 1'b1;
      case (adr[7:0])
        8'h00:   rv = {16'h0, h1};
        8'h04:   rv = {16'h0, m_out};
        8'h08:   rv = {16'h0, m_dir};
        8'h0C:   rv = {16'h0, m_en};
        8'h10:   rv = {16'h0, m_type};
        8'h14:   rv = {16'h0, m_stat};
        default: rv = 32'h0;
      endcase
      clr_m = 16'h0;
      if (req && we) begin
        case (adr[7:0])
          8'h04: m_out  = merge16(m_out, dat_i, sel);
          8'h08: m_dir  = merge16(m_dir, dat_i, sel);
          8'h0C: m_en   = merge16(m_en, dat_i, sel);
          8'h10: m_type = merge16(m_type, dat_i, sel);
          8'h14: clr_m  = merge16(16'h0, dat_i, sel);
          default: ;
        endcase
      end
      m_stat = (m_stat & ~clr_m) | set_m;
      m_rd   = req ? rv : 32'h0;
      m_ack  = req;
      h3 = h2; h2 = h1; h1 = io_in;
      if (since < 3) since++;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check_output("model ack", {31'h0, ack}, {31'h0, m_ack});
      check_output("model dat_o", dat_o, m_ack ? m_rd : 32'h0);
      check_output("model io_out", {16'h0, io_out}, {16'h0, m_out});
      check_output("model io_oeb", {16'h0, io_oeb}, {16'h0, ~m_dir});
      check_output("model irq", {29'h0, irq}, {31'h0, |m_stat});
    end
  end

  // ---------------- bus tasks (called at a negedge) ----------------
  task automatic bus_write(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s, output int lat);
    adr = BASE | {24'h0, off}; dat_i = d; sel = s; we = 1; cyc = 1; stb = 1; lat = 0;
    do begin @(negedge clk); lat++; end while (!ack && lat < 10);
    check_output("write ack seen", {31'h0, ack}, 32'h1);
    cyc = 0; stb = 0; we = 0;
    @(negedge clk);
  endtask

  task automatic bus_read(input logic [7:0] off, output logic [31:0] d, output int lat);
    adr = BASE | {24'h0, off}; sel = 4'hF; we = 0; cyc = 1; stb = 1; lat = 0;
    do begin @(negedge clk); lat++; end while (!ack && lat < 10);
    check_output("read ack seen", {31'h0, ack}, 32'h1);
    d = dat_o;
    cyc = 0; stb = 0;
    @(negedge clk);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int          lat;
    logic [31:0] rd;
    int          seen;
    logic [15:0] vec [8];
    vec = '{16'h0000, 16'h00F0, 16'hFF0F, 16'h1234, 16'hA5A5, 16'h5A5A, 16'hFFFF, 16'h0000};

    rst = 1; cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; dat_i = 0; io_in = 16'hFFFF;
    repeat (3) @(negedge clk);
    check_output("reset ack", {31'h0, ack}, 32'h0);
    check_output("reset dat_o", dat_o, 32'h0);
    check_output("reset io_out", {16'h0, io_out}, 32'h0);
    check_output("reset io_oeb", {16'h0, io_oeb}, 32'h0000FFFF);
    check_output("reset irq", {29'h0, irq}, 32'h0);

    // Enable every interrupt on the very first edge after release.
    rst = 0;
    bus_write(8'h0C, 32'h0000_FFFF, 4'hF, lat);
    check_output("first write latency", lat, 1);
    repeat (4) @(negedge clk);
    bus_read(8'h14, rd, lat);
    check_output("arm suppression stat", rd, 32'h0);
    check_output("arm suppression irq", {29'h0, irq}, 32'h0);

    bus_write(8'h08, 32'h0000_00FF, 4'b0011, lat);
    check_output("dir write latency", lat, 1);
    bus_write(8'h04, 32'h0000_A5A5, 4'b0011, lat);
    check_output("io_oeb after dir", {16'h0, io_oeb}, 32'h0000FF00);
    check_output("io_out after data", {16'h0, io_out}, 32'h0000A5A5);
    bus_write(8'h04, 32'h0000_1234, 4'b0001, lat);
    bus_read(8'h04, rd, lat);
    check_output("byte lane write", rd, 32'h0000A534);
    check_output("byte lane io_out", {16'h0, io_out}, 32'h0000A534);
    bus_write(8'h04, 32'hFFFF_FFFF, 4'hF, lat);
    bus_read(8'h04, rd, lat);
    check_output("upper bits read 0", rd, 32'h0000FFFF);

    // Rising edge on bit 3.
    io_in = 16'h0000;
    repeat (4) @(negedge clk);
    bus_write(8'h0C, 32'h0000_0008, 4'hF, lat);
    bus_write(8'h14, 32'h0000_FFFF, 4'hF, lat);
    io_in = 16'h0008;
    @(negedge clk);
    check_output("irq after k", {29'h0, irq}, 32'h0);
    @(negedge clk);
    check_output("irq after k+1", {29'h0, irq}, 32'h0);
    @(negedge clk);
    check_output("irq after k+2", {29'h0, irq}, 32'h1);
    bus_read(8'h14, rd, lat);
    check_output("rise stat", rd, 32'h0000_0008);
    bus_read(8'h00, rd, lat);
    check_output("data_in", rd, 32'h0000_0008);
    bus_write(8'h14, 32'h0000_0008, 4'hF, lat);
    bus_read(8'h14, rd, lat);
    check_output("w1c clears", rd, 32'h0);
    check_output("irq cleared", {29'h0, irq}, 32'h0);

    // Falling edge on bit 5, pending across disable, set beats clear.
    io_in = 16'h0028;
    repeat (4) @(negedge clk);
    bus_write(8'h10, 32'h0000_0020, 4'hF, lat);
    bus_write(8'h0C, 32'h0000_0028, 4'hF, lat);
    io_in = 16'h0008;
    repeat (3) @(negedge clk);
    bus_read(8'h14, rd, lat);
    check_output("fall stat", rd, 32'h0000_0020);
    bus_write(8'h0C, 32'h0000_0000, 4'hF, lat);
    bus_read(8'h14, rd, lat);
    check_output("stat kept after disable", rd, 32'h0000_0020);
    bus_write(8'h0C, 32'h0000_0020, 4'hF, lat);
    io_in = 16'h0028;
    repeat (4) @(negedge clk);
    io_in = 16'h0008;
    @(negedge clk);
    @(negedge clk);
    bus_write(8'h14, 32'h0000_0020, 4'hF, lat);
    bus_read(8'h14, rd, lat);
    check_output("set wins over clear", rd, 32'h0000_0020);
    bus_write(8'h14, 32'h0000_0020, 4'hF, lat);
    bus_read(8'h14, rd, lat);
    check_output("later clear", rd, 32'h0);

    // Unmapped offset and out-of-range address.
    bus_read(8'h40, rd, lat);
    check_output("unmapped read data", rd, 32'h0);
    check_output("unmapped read latency", lat, 1);
    adr = BASE + 32'h100; we = 0; sel = 4'hF; cyc = 1; stb = 1; seen = 0;
    repeat (10) begin @(negedge clk); if (ack) seen = 1; end
    check_output("out of range no ack", seen, 0);
    cyc = 0; stb = 0;
    @(negedge clk);

    // Model-driven sweep with mixed edge types and partial clears.
    bus_write(8'h0C, 32'h0000_FFFF, 4'hF, lat);
    bus_write(8'h10, 32'h0000_0F0F, 4'hF, lat);
    for (int v = 0; v < 8; v++) begin
      io_in = vec[v];
      repeat (3) @(negedge clk);
      bus_read(8'h14, rd, lat);
      check_output("sweep stat vs model", rd, {16'h0, m_stat});
      bus_write(8'h14, 32'h0000_00FF, 4'b0001, lat);
    end

    // Reset during the ack cycle of a DATA_OUT write.
    adr = BASE | 32'h04; dat_i = 32'h0000_1111; sel = 4'hF; we = 1; cyc = 1; stb = 1;
    @(negedge clk);
    check_output("abort ack cycle", {31'h0, ack}, 32'h1);
    rst = 1; cyc = 0; stb = 0; we = 0;
    @(negedge clk);
    check_output("abort ack after reset", {31'h0, ack}, 32'h0);
    check_output("abort io_out", {16'h0, io_out}, 32'h0);
    check_output("abort io_oeb", {16'h0, io_oeb}, 32'h0000FFFF);
    rst = 0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
